// File: rtl/rom_seq_reader_pkg.sv
// rom_seq_pkg
//   Shared definitions for the pattern-ROM sequencer: FSM state encoding,
//   default geometry of the 16-entry pattern ROM and the stream handshake
//   helper used by the top level.
package rom_seq_pkg;

    localparam int unsigned DEF_ADDR_W    = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_LAST_ADDR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

    // A word transfers on the stream when both sides agree in the same cycle.
    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/rom_seq_addr_gen.sv
// rom_seq_addr_gen
//   Owns the registered ROM address. restart returns to address 0 (and, in
//   ping-pong builds, forces the direction up); step moves to the next address
//   of the playback sequence. The caller only steps at LAST_ADDR when looping,
//   so stepping there always means wrap (or reverse).
//   Optional build macro: ROM_SEQ_PINGPONG_EN (reverse at each end instead of
//   wrapping to 0).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   restart     load address 0
//   step        advance to the next address
//   addr        registered ROM address
//   at_last     addr equals LAST_ADDR
module rom_seq_addr_gen #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned LAST_ADDR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    assign at_last = (addr == LAST);

`ifdef ROM_SEQ_PINGPONG_EN
    logic dir_down;

    // Endpoints are turned around without being replayed: LAST goes to
    // LAST-1 and 0 goes to 1. A degenerate LAST_ADDR of 0 just stays at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            dir_down <= 1'b0;
        end else if (restart) begin
            addr     <= '0;
            dir_down <= 1'b0;
        end else if (step) begin
            if (!dir_down) begin
                if (at_last) begin
                    dir_down <= (LAST != '0);
                    addr     <= (LAST == '0) ? '0 : LAST - ONE;
                end else begin
                    addr <= addr + ONE;
                end
            end else begin
                if (addr == '0) begin
                    dir_down <= 1'b0;
                    addr     <= (LAST == '0) ? '0 : ONE;
                end else begin
                    addr <= addr - ONE;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (restart) begin
            addr <= '0;
        end else if (step) begin
            addr <= at_last ? '0 : addr + ONE;
        end
    end
`endif

endmodule

// File: rtl/rom_seq_reader.sv
// rom_seq_reader
//   Walks the pattern ROM from address 0 to LAST_ADDR and streams each byte
//   to a valid/ready consumer, one word per two cycles at full throughput.
//   Single-pass or looping playback; stop ends playback at the next
//   handshake (or at once while fetching).
//   Optional build macro: ROM_SEQ_PINGPONG_EN (looping reverses direction).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a pass at address 0 (sampled while idle)
//   stop        end playback
//   loop        1 = restart after LAST_ADDR, 0 = single pass
//   rom_addr    registered ROM address
//   rom_data    combinational ROM read data
//   out_data    stream data, out_valid / out_ready handshake
//   busy        high whenever not idle
//   done        one-cycle pulse on natural completion
module rom_seq_reader
    import rom_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LAST_ADDR = DEF_LAST_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    seq_state_t state, state_n;
    logic       valid_n, done_n, load_data;
    logic       stop_lat, stop_lat_n;
    logic       restart, step, at_last, fire;

    rom_seq_addr_gen #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .step    (step),
        .addr    (rom_addr),
        .at_last (at_last)
    );

    assign busy = (state != IDLE);
    assign fire = hs_fire(out_valid, out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            stop_lat  <= 1'b0;
        end else begin
            out_valid <= valid_n;
            done      <= done_n;
            stop_lat  <= stop_lat_n;
            if (load_data) out_data <= rom_data;
        end
    end

    always_comb begin
        state_n    = state;
        valid_n    = out_valid;
        done_n     = 1'b0;
        load_data  = 1'b0;
        stop_lat_n = stop_lat;
        restart    = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                stop_lat_n = 1'b0;
                if (start && !stop) begin
                    restart = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                stop_lat_n = 1'b0;
                if (stop) begin
                    state_n = IDLE;
                end else begin
                    load_data = 1'b1;
                    valid_n   = 1'b1;
                    state_n   = HOLD;
                end
            end
            HOLD: begin
                // A stop pulse during backpressure is remembered until the
                // word is finally accepted.
                if (stop) stop_lat_n = 1'b1;
                if (fire) begin
                    valid_n    = 1'b0;
                    stop_lat_n = 1'b0;
                    if (stop || stop_lat) begin
                        state_n = IDLE;
                    end else if (!at_last || loop) begin
                        step    = 1'b1;
                        state_n = FETCH;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Self-checking bench for rom_seq_reader: directed scenarios plus randomized
// start/stop/loop/ready traffic compared cycle by cycle to a reference model
// that derives the address from a word position counter.
module tb_rom_seq_reader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int LAST   = 10;

    localparam logic [7:0] ROM_IMG [16] = '{
        8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128,
        8'd170, 8'd85, 8'd153, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, stop = 1'b0, loop = 1'b0, out_ready = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data, out_data;
    logic              out_valid, busy, done;

    always #5 clk = ~clk;
    assign rom_data = ROM_IMG[rom_addr];

    rom_seq_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LAST_ADDR (LAST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [7:0] acc_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Address of the p-th word of a pass.
    function automatic int seq_addr(input int p);
`ifdef ROM_SEQ_PINGPONG_EN
        int a;
        if (LAST == 0) return 0;
        a = p % (2 * LAST);
        return (a <= LAST) ? a : 2 * LAST - a;
`else
        return p % (LAST + 1);
`endif
    endfunction

    bit       m_busy = 0, m_fetch = 0, m_valid = 0, m_done = 0, m_stop = 0;
    int       m_pos = 0, m_addr = 0;
    logic [7:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0; m_stop = 0;
            m_pos = 0; m_addr = 0; m_data = '0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    m_busy = 1; m_fetch = 1; m_pos = 0;
                end
            end else if (m_fetch) begin
                m_fetch = 0;
                if (stop) m_busy = 0;
                else begin
                    m_data = ROM_IMG[m_addr]; m_valid = 1; m_stop = 0;
                end
            end else if (out_ready) begin
                m_valid = 0;
                if (stop || m_stop) m_busy = 0;
                else if (m_addr != LAST || loop) begin
                    m_pos++; m_fetch = 1;
                end else begin
                    m_busy = 0; m_done = 1;
                end
                m_stop = 0;
            end else if (stop) begin
                m_stop = 1;
            end
            m_addr = seq_addr(m_pos);
        end
    end

    // Accepted-word monitor.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) acc_q.push_back(out_data);
    end

    task automatic tick();
        @(negedge clk);
        if (done) done_cnt++;
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("rom_addr", rom_addr, m_addr);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        acc_q.delete();
        done_cnt = 0;
    endtask

    int exp_seq [11] = '{1, 2, 4, 8, 16, 32, 64, 128, 170, 85, 153};
    bit found;

    initial begin
        do_reset();

        // Reset mid-pass at address 5 with valid high.
        loop = 1'b0; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (out_valid && rom_addr == 4'd5) found = 1;
        end
        chk("rst_reach_a5", found, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_no_output", out_valid, 0);

        // Single pass.
        do_reset();
        loop = 1'b0; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        repeat (30) tick();
        chk("pass_len", acc_q.size(), 11);
        for (int i = 0; i < 11; i++) chk("pass_word", acc_q[i], exp_seq[i]);
        chk("pass_done_cnt", done_cnt, 1);
        chk("pass_busy_end", busy, 0);

        // Backpressure on word 4.
        do_reset();
        out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (out_valid && out_data == 8'd4) found = 1;
        end
        chk("bp_reach_4", found, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data", out_data, 4);
            chk("bp_valid", out_valid, 1);
            chk("bp_addr", rom_addr, 2);
        end
        out_ready = 1'b1;
        tick(); tick();
        chk("bp_next_data", out_data, 8);
        chk("bp_next_valid", out_valid, 1);

        // Stop pulse during backpressure on word 8.
        do_reset();
        out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (out_valid && out_data == 8'd8) found = 1;
        end
        chk("stop_reach_8", found, 1);
        out_ready = 1'b0; stop = 1'b1;
        tick(); stop = 1'b0;
        tick(); tick();
        chk("stop_hold_valid", out_valid, 1);
        chk("stop_hold_data", out_data, 8);
        out_ready = 1'b1;
        tick();
        chk("stop_busy", busy, 0);
        chk("stop_valid", out_valid, 0);
        repeat (4) tick();
        chk("stop_no_words", out_valid, 0);
        chk("stop_no_done", done_cnt, 0);
        start = 1'b1; stop = 1'b1;
        tick(); tick();
        chk("start_stop_idle", busy, 0);
        start = 1'b0; stop = 1'b0;

        // Looping playback, stop, restart, then finish with loop cleared.
        do_reset();
        loop = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        repeat (30) tick();
        chk("loop_enough", acc_q.size() >= 13, 1);
        chk("loop_w10", acc_q[10], 153);
`ifdef ROM_SEQ_PINGPONG_EN
        chk("loop_w11", acc_q[11], 85);
        chk("loop_w12", acc_q[12], 170);
`else
        chk("loop_w11", acc_q[11], 1);
        chk("loop_w12", acc_q[12], 2);
`endif
        chk("loop_no_done", done_cnt, 0);
        stop = 1'b1;
        tick(); stop = 1'b0;
        repeat (6) tick();
        chk("loop_stopped", busy, 0);
        acc_q.delete();
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (8) tick();
        chk("restart_w0", acc_q[0], 1);
        chk("restart_w1", acc_q[1], 2);
        loop = 1'b0;
        repeat (60) tick();
        chk("loop_end_done", done_cnt, 1);
        chk("loop_end_busy", busy, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 4) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) loop = ~loop;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
